// File: rtl/video_axis_pkg.sv
// Shared video AXI4-Stream definitions.
// Used by pad, crop and pattern stages.
package video_axis_pkg;

  localparam int SOF_BIT = 0;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FLUSH
  } pad_state_t;

  // True when (h, v) lies in the w x ht box at (x0, y0).
  // The upper bounds are widened by one bit so x0 + w cannot wrap.
  function automatic logic in_window(
    input logic [CNT_W-1:0] h,
    input logic [CNT_W-1:0] v,
    input logic [CNT_W-1:0] x0,
    input logic [CNT_W-1:0] y0,
    input logic [CNT_W-1:0] w,
    input logic [CNT_W-1:0] ht
  );
    logic [CNT_W:0] x1;
    logic [CNT_W:0] y1;
    x1 = {1'b0, x0} + {1'b0, w};
    y1 = {1'b0, y0} + {1'b0, ht};
    return (h >= x0) && ({1'b0, h} < x1) &&
           (v >= y0) && ({1'b0, v} < y1);
  endfunction

endpackage

// File: rtl/video_raster_cnt.sv
// Raster h/v position counter with wrap.
// frame_done pulses when the last pixel advances.
module video_raster_cnt
  import video_axis_pkg::*;
#(
  parameter int WIDTH  = 1920,
  parameter int HEIGHT = 1080
) (
  input  logic             axis_clk,
  input  logic             aresetn,
  input  logic             en,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             frame_done
);

  logic h_last;
  logic v_last;

  assign h_last     = (h_cnt == CNT_W'(WIDTH - 1));
  assign v_last     = (v_cnt == CNT_W'(HEIGHT - 1));
  assign frame_done = en & h_last & v_last;

  // Advance one pixel per enable, wrapping line then frame.
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_video_pad.sv
// Embeds an input frame in a larger fill-coloured canvas.
// Output raster drives the flow; window pixels pass through.
module axis_video_pad
  import video_axis_pkg::*;
#(
  parameter int VIDEO_IN_W = 640,
  parameter int VIDEO_IN_H = 480,
  parameter int VIDEO_OUT_W = 1920,
  parameter int VIDEO_OUT_H = 1080,
  parameter int H_OFFSET = 640,
  parameter int V_OFFSET = 300,
  parameter int DATA_WIDTH = 24,
  parameter int USER_WIDTH = 1,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
  input  logic                  axis_clk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  sof_err,
  output logic                  eol_err,
  output logic [15:0]           h_ptr,
  output logic [15:0]           v_ptr
);

  if (H_OFFSET + VIDEO_IN_W > VIDEO_OUT_W ||
      V_OFFSET + VIDEO_IN_H > VIDEO_OUT_H) begin : g_bad_geom
    $fatal(1, "axis_video_pad: input window exceeds canvas");
  end

  pad_state_t state;
  pad_state_t state_n;
  logic       win;
  logic       first_px;
  logic       last_col;
  logic       sof_in;
  logic       sof_set;
  logic       eol_set;
  logic       out_fire;
  logic       frame_done;

  assign sof_in   = s_axis_tuser[SOF_BIT];
  assign out_fire = m_axis_tvalid & m_axis_tready;

  assign win = in_window(h_ptr, v_ptr,
                         CNT_W'(H_OFFSET), CNT_W'(V_OFFSET),
                         CNT_W'(VIDEO_IN_W), CNT_W'(VIDEO_IN_H));

  assign first_px = (h_ptr == CNT_W'(H_OFFSET)) &&
                    (v_ptr == CNT_W'(V_OFFSET));
  assign last_col = (h_ptr == CNT_W'(H_OFFSET + VIDEO_IN_W - 1));

  assign m_axis_tlast = (h_ptr == CNT_W'(VIDEO_OUT_W - 1));
  assign m_axis_tuser = USER_WIDTH'(h_ptr == '0 && v_ptr == '0);

  video_raster_cnt #(
    .WIDTH (VIDEO_OUT_W),
    .HEIGHT(VIDEO_OUT_H)
  ) u_cnt (
    .axis_clk  (axis_clk),
    .aresetn   (aresetn),
    .en        (out_fire),
    .h_cnt     (h_ptr),
    .v_cnt     (v_ptr),
    .frame_done(frame_done)
  );

  // State and sticky error flags; the last fired pixel ends the frame.
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      state   <= IDLE;
      sof_err <= 1'b0;
      eol_err <= 1'b0;
    end else begin
      state <= frame_done ? IDLE : state_n;
      if (sof_set) sof_err <= 1'b1;
      if (eol_set) eol_err <= 1'b1;
    end
  end

  // Next state, datapath mux and handshakes; all idle in reset.
  // A misplaced SOF in the window is held back so it opens the next frame.
  always_comb begin
    state_n       = state;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = FILL_VALUE;
    s_axis_tready = 1'b0;
    sof_set       = 1'b0;
    eol_set       = 1'b0;
    if (aresetn) begin
      unique case (state)
        IDLE: begin
          s_axis_tready = !(s_axis_tvalid & sof_in);
          if (s_axis_tvalid & sof_in) state_n = ACTIVE;
        end
        ACTIVE: begin
          if (!win) begin
            m_axis_tvalid = 1'b1;
          end else if (s_axis_tvalid & (first_px ^ sof_in)) begin
            sof_set = 1'b1;
            state_n = FLUSH;
          end else begin
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tdata  = s_axis_tdata;
            s_axis_tready = m_axis_tready;
            eol_set = s_axis_tvalid & m_axis_tready &
                      (s_axis_tlast != last_col);
          end
        end
        FLUSH: begin
          m_axis_tvalid = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_video_pad.sv
// Directed bench for axis_video_pad on a 4x3 in 8x6 canvas.
// Output beats are compared against a raster model built here.
module tb_axis_video_pad;

  localparam logic [23:0] FILL = 24'hABCDEF;

  logic        axis_clk = 1'b0;
  logic        aresetn;
  logic [23:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [0:0]  s_axis_tuser;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [0:0]  m_axis_tuser;
  logic        sof_err;
  logic        eol_err;
  logic [15:0] h_ptr;
  logic [15:0] v_ptr;

  int checks = 0;
  int errors = 0;

  logic [23:0] src_d[$];
  logic        src_u[$];
  logic        src_l[$];
  logic [23:0] o_d[$];
  logic        o_u[$];
  logic        o_l[$];
  logic [23:0] e_d[$];
  logic        e_u[$];
  logic        e_l[$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  axis_video_pad #(
    .VIDEO_IN_W (4),
    .VIDEO_IN_H (3),
    .VIDEO_OUT_W(8),
    .VIDEO_OUT_H(6),
    .H_OFFSET   (2),
    .V_OFFSET   (1),
    .DATA_WIDTH (24),
    .USER_WIDTH (1),
    .FILL_VALUE (FILL)
  ) dut (
    .axis_clk     (axis_clk),
    .aresetn      (aresetn),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tuser (s_axis_tuser),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .sof_err      (sof_err),
    .eol_err      (eol_err),
    .h_ptr        (h_ptr),
    .v_ptr        (v_ptr)
  );

  always #5 axis_clk = ~axis_clk;

  task automatic push_px(input int d, input logic u, input logic l);
    src_d.push_back(24'(d));
    src_u.push_back(u);
    src_l.push_back(l);
  endtask

  task automatic push_frame(input int base, input int n);
    for (int i = 0; i < n; i++)
      push_px(base + i, i == 0, (i % 4) == 3);
  endtask

  task automatic build_exp(input int base, input int npass);
    for (int b = 0; b < 48; b++) begin
      int h;
      int v;
      int k;
      h = b % 8;
      v = b / 8;
      k = (v - 1) * 4 + (h - 2);
      if (h >= 2 && h <= 5 && v >= 1 && v <= 3 && k < npass)
        e_d.push_back(24'(base + k));
      else
        e_d.push_back(FILL);
      e_u.push_back(b == 0);
      e_l.push_back(h == 7);
    end
  endtask

  task automatic send(input int gap);
    int   cyc;
    logic f;
    cyc = 0;
    while (src_d.size() != 0 && cyc < 4000) begin
      if (gap != 0 && $urandom_range(99) < gap) begin
        s_axis_tvalid = 1'b0;
        @(posedge axis_clk);
        #1;
        cyc++;
      end else begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = src_d[0];
        s_axis_tuser  = src_u[0];
        s_axis_tlast  = src_l[0];
        f = 1'b0;
        while (!f && cyc < 4000) begin
          @(negedge axis_clk);
          f = s_axis_tready;
          @(posedge axis_clk);
          #1;
          cyc++;
        end
        if (f) begin
          void'(src_d.pop_front());
          void'(src_u.pop_front());
          void'(src_l.pop_front());
        end
      end
    end
    s_axis_tvalid = 1'b0;
    chk("src_drained", src_d.size(), 0);
  endtask

  task automatic recv(input int n, input int rdy);
    int          cyc;
    logic        held;
    logic [23:0] pd;
    logic        pu;
    logic        pl;
    cyc  = 0;
    held = 1'b0;
    pd   = '0;
    pu   = 1'b0;
    pl   = 1'b0;
    while (o_d.size() < n && cyc < 4000) begin
      m_axis_tready = (rdy >= 100) ? 1'b1 : ($urandom_range(99) < rdy);
      @(negedge axis_clk);
      if (held)
        chk("stall_hold",
            {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast},
            {1'b1, pd, pu, pl});
      if (m_axis_tvalid && m_axis_tready) begin
        o_d.push_back(m_axis_tdata);
        o_u.push_back(m_axis_tuser[0]);
        o_l.push_back(m_axis_tlast);
      end
      held = m_axis_tvalid && !m_axis_tready;
      pd   = m_axis_tdata;
      pu   = m_axis_tuser[0];
      pl   = m_axis_tlast;
      @(posedge axis_clk);
      #1;
      cyc++;
    end
    m_axis_tready = 1'b1;
    chk("beat_count", o_d.size(), n);
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".len"}, o_d.size(), e_d.size());
    for (int i = 0; i < e_d.size() && i < o_d.size(); i++) begin
      chk($sformatf("%s.data[%0d]", tag, i), o_d[i], e_d[i]);
      chk($sformatf("%s.side[%0d]", tag, i),
          {o_u[i], o_l[i]}, {e_u[i], e_l[i]});
    end
    o_d.delete(); o_u.delete(); o_l.delete();
    e_d.delete(); e_u.delete(); e_l.delete();
  endtask

  initial begin
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 24'h55AA55;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;

    repeat (2) @(posedge axis_clk);
    @(negedge axis_clk);
    chk("rst_mvalid", m_axis_tvalid, 1'b0);
    chk("rst_sready", s_axis_tready, 1'b0);
    chk("rst_ptrs", {h_ptr, v_ptr}, 32'h0);
    chk("rst_flags", {sof_err, eol_err}, 2'b00);
    @(posedge axis_clk);
    #1;
    aresetn       = 1'b1;
    s_axis_tvalid = 1'b0;
    @(negedge axis_clk);
    chk("idle_sready", s_axis_tready, 1'b1);
    chk("idle_mvalid", m_axis_tvalid, 1'b0);
    @(posedge axis_clk);
    #1;

    push_frame(1, 12);
    build_exp(1, 12);
    fork
      send(0);
      recv(48, 100);
    join
    check_out("clean");
    chk("clean_flags", {sof_err, eol_err}, 2'b00);

    push_px(24'h111111, 1'b0, 1'b0);
    push_px(24'h222222, 1'b0, 1'b1);
    push_px(24'h333333, 1'b0, 1'b0);
    push_frame(1, 12);
    build_exp(1, 12);
    fork
      send(0);
      recv(48, 100);
    join
    check_out("garbage");
    chk("garbage_flags", {sof_err, eol_err}, 2'b00);

    push_frame(1, 12);
    build_exp(1, 12);
    fork
      send(30);
      recv(48, 50);
    join
    check_out("stall");
    chk("stall_flags", {sof_err, eol_err}, 2'b00);

    push_frame(1, 6);
    push_frame(7, 12);
    build_exp(1, 6);
    build_exp(7, 12);
    fork
      send(0);
      recv(96, 100);
    join
    check_out("early_sof");
    chk("early_sof_err", sof_err, 1'b1);
    chk("early_eol_err", eol_err, 1'b0);

    aresetn = 1'b0;
    @(posedge axis_clk);
    #1;
    aresetn = 1'b1;
    @(negedge axis_clk);
    chk("rst2_flags", {sof_err, eol_err}, 2'b00);
    @(posedge axis_clk);
    #1;

    for (int i = 0; i < 12; i++)
      push_px(1 + i, i == 0, i == 2 || i == 7 || i == 11);
    build_exp(1, 12);
    fork
      send(0);
      recv(48, 100);
    join
    check_out("bad_eol");
    chk("bad_eol_err", eol_err, 1'b1);
    chk("bad_eol_sof", sof_err, 1'b0);

    push_frame(1, 6);
    fork
      send(0);
      recv(20, 100);
    join
    o_d.delete(); o_u.delete(); o_l.delete();
    @(negedge axis_clk);
    chk("mid_ptrs", {h_ptr, v_ptr}, {16'd4, 16'd2});
    @(posedge axis_clk);
    #1;
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 24'd7;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    @(negedge axis_clk);
    chk("mid_rst_mvalid", m_axis_tvalid, 1'b0);
    chk("mid_rst_sready", s_axis_tready, 1'b0);
    @(posedge axis_clk);
    #1;
    aresetn       = 1'b1;
    s_axis_tvalid = 1'b0;
    @(negedge axis_clk);
    chk("mid_rst_ptrs", {h_ptr, v_ptr}, 32'h0);
    chk("mid_rst_flags", {sof_err, eol_err}, 2'b00);
    @(posedge axis_clk);
    #1;

    push_frame(1, 12);
    build_exp(1, 12);
    fork
      send(0);
      recv(48, 100);
    join
    check_out("after_rst");
    chk("after_rst_flags", {sof_err, eol_err}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
